// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity constants and parity helper.
// Also used by the parametrised RX path.
package uart_pkg;

   localparam int MAX_DATA_WID = 9;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_e;

   // Narrower words must be zero-extended by the caller; padding zeros do not change the XOR.
   function automatic logic parity_bit(input logic [MAX_DATA_WID-1:0] data, input logic typ);
      logic p;
      logic r;
      p = ^data;
      case (typ)
         PAR_EVEN: r = p;
         PAR_ODD:  r = ~p;
         default:  r = p;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Word handshake, frame configuration and serial/status signals of the configurable UART TX.
interface uart_tx_cfg_if #(
   parameter int DATA_WID = 8,
   parameter int DIV_WID  = 16
) ();

   logic [DATA_WID-1:0] s_data;
   logic                s_valid;
   logic                s_ready;
   logic                par_en;
   logic                par_typ;
   logic                stop2;
   logic [DIV_WID-1:0]  baud_div;
   logic                busy;
   logic                frame_done;
   logic                tx_out;

   modport master (
      output s_data, s_valid, par_en, par_typ, stop2, baud_div,
      input  s_ready, busy, frame_done, tx_out
   );

   modport slave (
      input  s_data, s_valid, par_en, par_typ, stop2, baud_div,
      output s_ready, busy, frame_done, tx_out
   );

endinterface

// File: rtl/uart_baud_cnt.sv
// Reload/terminal-count bit-period divider: bit_end_o is high on the last clock of each bit.
// A zero divisor is treated as one clock per bit.
module uart_baud_cnt #(
   parameter int DIV_WID = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_i,
   input  logic               en_i,
   input  logic [DIV_WID-1:0] div_i,
   output logic               bit_end_o
);

   logic [DIV_WID-1:0] div_q, div_d;
   logic [DIV_WID-1:0] cnt_q, cnt_d;

   always_comb begin
      div_d = div_q;
      cnt_d = cnt_q;
      if (load_i) begin
         div_d = (div_i == '0) ? DIV_WID'(1) : div_i;
         cnt_d = div_d - 1'b1;
      end else if (en_i) begin
         if (cnt_q == '0) begin
            cnt_d = div_q - 1'b1;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= DIV_WID'(1);
         cnt_q <= '0;
      end else begin
         div_q <= div_d;
         cnt_q <= cnt_d;
      end
   end

   assign bit_end_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start, DATA_WID data bits LSB first, optional parity,
// one or two stop bits; frame settings are captured when the word is accepted.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int DATA_WID = 8,
   parameter int DIV_WID  = 16
) (
   input  logic          clk,
   input  logic          rst,
   uart_tx_cfg_if.slave  bus
);

   localparam int             BCW      = $clog2(DATA_WID);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WID - 1);

   state_e              state_q, state_d;
   logic [DATA_WID-1:0] shift_q, shift_d;
   logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
   logic                stop_cnt_q, stop_cnt_d;
   logic                par_en_q, par_en_d;
   logic                stop2_q, stop2_d;
   logic                par_bit_q, par_bit_d;
   logic                tx_q, tx_d;
   logic                rdy_q;
   logic                accept;
   logic                bit_end;
   logic                last_stop;

   // rdy_q keeps the source stalled while reset is held, and opens on the first clock after.
   assign bus.s_ready = rdy_q && (state_q == IDLE);
   assign accept      = bus.s_valid && bus.s_ready;

   uart_baud_cnt #(
      .DIV_WID (DIV_WID)
   ) u_baud (
      .clk       (clk),
      .rst       (rst),
      .load_i    (accept),
      .en_i      (state_q != IDLE),
      .div_i     (bus.baud_div),
      .bit_end_o (bit_end)
   );

   assign last_stop = (state_q == STOP) && bit_end && !(stop2_q && !stop_cnt_q);

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      par_en_d   = par_en_q;
      stop2_d    = stop2_q;
      par_bit_d  = par_bit_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d    = START;
               shift_d    = bus.s_data;
               par_en_d   = bus.par_en;
               stop2_d    = bus.stop2;
               par_bit_d  = parity_bit(MAX_DATA_WID'(bus.s_data), bus.par_typ);
               bit_cnt_d  = '0;
               stop_cnt_d = 1'b0;
            end
         end
         START: begin
            if (bit_end) state_d = DATA;
         end
         DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = par_en_q ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         PARITY: begin
            if (bit_end) state_d = STOP;
         end
         STOP: begin
            if (bit_end) begin
               if (last_stop) state_d = IDLE;
               else           stop_cnt_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Line level is decided from the next state so TX_OUT changes together with the state.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PARITY:  tx_d = par_bit_q;
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         par_en_q   <= 1'b0;
         stop2_q    <= 1'b0;
         par_bit_q  <= 1'b0;
         tx_q       <= 1'b1;
         rdy_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         par_en_q   <= par_en_d;
         stop2_q    <= stop2_d;
         par_bit_q  <= par_bit_d;
         tx_q       <= tx_d;
         rdy_q      <= 1'b1;
      end
   end

   assign bus.busy       = (state_q != IDLE);
   assign bus.frame_done = last_stop;
   assign bus.tx_out     = tx_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: 8-bit and 5-bit instances, each frame compared cycle by cycle
// against a line-level waveform built from the frame format.
module tb_uart_tx_cfg;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_tx_cfg_if #(.DATA_WID(8), .DIV_WID(16)) bus8 ();
   uart_tx_cfg_if #(.DATA_WID(5), .DIV_WID(16)) bus5 ();

   uart_tx_cfg #(.DATA_WID(8), .DIV_WID(16)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
   uart_tx_cfg #(.DATA_WID(5), .DIV_WID(16)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

   int checks = 0;
   int errors = 0;
   bit sel5   = 1'b0;

   function automatic logic o_tx();    return sel5 ? bus5.tx_out     : bus8.tx_out;     endfunction
   function automatic logic o_busy();  return sel5 ? bus5.busy       : bus8.busy;       endfunction
   function automatic logic o_done();  return sel5 ? bus5.frame_done : bus8.frame_done; endfunction
   function automatic logic o_ready(); return sel5 ? bus5.s_ready    : bus8.s_ready;    endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [8:0] d, input bit pe, input bit pt, input bit s2,
                        input logic [15:0] div);
      bus8.s_data   = d[7:0];
      bus5.s_data   = d[4:0];
      bus8.par_en   = pe;  bus5.par_en   = pe;
      bus8.par_typ  = pt;  bus5.par_typ  = pt;
      bus8.stop2    = s2;  bus5.stop2    = s2;
      bus8.baud_div = div; bus5.baud_div = div;
   endtask

   task automatic set_valid(input bit v);
      bus8.s_valid = v & !sel5;
      bus5.s_valid = v & sel5;
   endtask

   // Entered and left on a falling edge. hold keeps S_VALID high through the frame,
   // b2b requires acceptance without waiting, scramble changes every input mid-frame,
   // abort_at >= 0 pulses reset in that frame cycle and abandons the frame.
   task automatic frame(input logic [8:0] d, input bit pe, input bit pt, input bit s2,
                        input logic [15:0] div, input bit hold, input bit b2b,
                        input bit scramble, input int abort_at);
      int dw;
      int dv;
      int ones;
      int len;
      int w;
      int busy_n;
      int done_n;
      bit lv[$];
      dw = sel5 ? 5 : 8;
      dv = (div == 16'd0) ? 1 : int'(div);
      ones = 0; w = 0; busy_n = 0; done_n = 0;
      lv.push_back(1'b0);
      for (int b = 0; b < dw; b++) begin
         lv.push_back(d[b]);
         ones += int'(d[b]);
      end
      if (pe) lv.push_back((ones % 2 == 1) ^ pt);
      lv.push_back(1'b1);
      if (s2) lv.push_back(1'b1);
      len = lv.size() * dv;

      drive(d, pe, pt, s2, div);
      set_valid(1'b1);
      while (o_ready() !== 1'b1 && w < 64) begin
         @(negedge clk);
         w++;
      end
      chk("ready_wait", 32'(o_ready()), 32'd1);
      if (b2b) chk("idle_gap", w, 0);
      @(negedge clk);
      if (!hold) set_valid(1'b0);

      for (int i = 0; i < len; i++) begin
         if (scramble && i == len / 2) drive(9'($urandom), ~pe, 1'($urandom), ~s2, 16'd9);
         chk($sformatf("tx d=%0h cyc%0d", d, i), 32'(o_tx()), 32'(lv[i / dv]));
         chk($sformatf("busy cyc%0d", i), 32'(o_busy()), 32'd1);
         chk($sformatf("done cyc%0d", i), 32'(o_done()), 32'(i == len - 1));
         busy_n += int'(o_busy());
         done_n += int'(o_done());
         if (i == abort_at) begin
            #2 rst = 1'b1;
            #1;
            chk("rst_tx", 32'(o_tx()), 32'd1);
            chk("rst_busy", 32'(o_busy()), 32'd0);
            chk("rst_ready", 32'(o_ready()), 32'd0);
            chk("rst_done", 32'(o_done()), 32'd0);
            set_valid(1'b0);
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            chk("rst_release_ready", 32'(o_ready()), 32'd1);
            chk("rst_release_tx", 32'(o_tx()), 32'd1);
            $display("frame d=%0h aborted by reset at cycle %0d", d, i);
            return;
         end
         @(negedge clk);
      end
      chk("idle_tx", 32'(o_tx()), 32'd1);
      chk("idle_busy", 32'(o_busy()), 32'd0);
      chk("idle_ready", 32'(o_ready()), 32'd1);
      chk("busy_len", busy_n, len);
      chk("done_count", done_n, 1);
      $display("frame w%0d d=%0h pe=%0b pt=%0b s2=%0b div=%0d len=%0d wait=%0d",
               dw, d, pe, pt, s2, div, len, w);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      sel5 = 1'b0;
      drive(9'd0, 1'b0, 1'b0, 1'b0, 16'd1);
      bus8.s_valid = 1'b0;
      bus5.s_valid = 1'b0;
      repeat (2) @(negedge clk);

      for (int s = 0; s < 2; s++) begin
         sel5 = (s == 1);
         chk("reset_tx", 32'(o_tx()), 32'd1);
         chk("reset_busy", 32'(o_busy()), 32'd0);
         chk("reset_done", 32'(o_done()), 32'd0);
         chk("reset_ready", 32'(o_ready()), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel5 = (s == 1);
         chk("post_reset_ready", 32'(o_ready()), 32'd1);
      end
      sel5 = 1'b0;

      frame(9'h0A5, 1'b0, 1'b0, 1'b0, 16'd4, 1'b0, 1'b0, 1'b0, -1);
      frame(9'h007, 1'b1, 1'b0, 1'b0, 16'd4, 1'b0, 1'b0, 1'b0, -1);
      frame(9'h007, 1'b1, 1'b1, 1'b0, 16'd4, 1'b0, 1'b0, 1'b0, -1);
      frame(9'h0C3, 1'b0, 1'b0, 1'b1, 16'd3, 1'b0, 1'b0, 1'b0, -1);

      frame(9'h011, 1'b0, 1'b0, 1'b0, 16'd2, 1'b1, 1'b0, 1'b0, -1);
      frame(9'h022, 1'b0, 1'b0, 1'b0, 16'd2, 1'b1, 1'b1, 1'b0, -1);
      frame(9'h033, 1'b0, 1'b0, 1'b0, 16'd2, 1'b0, 1'b1, 1'b0, -1);

      frame(9'h05A, 1'b0, 1'b0, 1'b0, 16'd4, 1'b0, 1'b0, 1'b1, -1);
      frame(9'h05A, 1'b1, 1'b1, 1'b0, 16'd9, 1'b0, 1'b0, 1'b0, -1);

      sel5 = 1'b1;
      frame(9'h015, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, -1);

      for (int k = 0; k < 24; k++) begin
         sel5 = 1'($urandom);
         frame(9'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               16'($urandom_range(0, 6)), 1'b0, 1'b0, 1'($urandom), -1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      sel5 = 1'b0;
      frame(9'h0F0, 1'b0, 1'b0, 1'b0, 16'd4, 1'b0, 1'b0, 1'b0, 17);
      frame(9'h03C, 1'b0, 1'b0, 1'b0, 16'd4, 1'b0, 1'b0, 1'b0, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
